// File: rtl/mem_port_arbiter_if.sv
// Bundle shared by the fetch port, the data port and the main-memory port.
// The arbiter takes the slave view; requesters and memory take the master view.
interface mem_port_arbiter_if;
   logic        i_read;
   logic [31:0] i_address;
   logic [31:0] i_readdata;
   logic        i_busywait;

   logic        d_read;
   logic        d_write;
   logic [31:0] d_address;
   logic [31:0] d_writedata;
   logic [3:0]  d_byteen;
   logic [31:0] d_readdata;
   logic        d_busywait;

   logic        m_read;
   logic        m_write;
   logic [31:0] m_address;
   logic [31:0] m_writedata;
   logic [3:0]  m_byteen;
   logic [31:0] m_readdata;
   logic        m_ready;
   logic        bus_error;

   modport slave (
      input  i_read, i_address, d_read, d_write, d_address, d_writedata, d_byteen,
             m_readdata, m_ready,
      output i_readdata, i_busywait, d_readdata, d_busywait,
             m_read, m_write, m_address, m_writedata, m_byteen, bus_error
   );

   modport master (
      output i_read, i_address, d_read, d_write, d_address, d_writedata, d_byteen,
             m_readdata, m_ready,
      input  i_readdata, i_busywait, d_readdata, d_busywait,
             m_read, m_write, m_address, m_writedata, m_byteen, bus_error
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between instruction fetch and data access,
// round-robin on ties, with a per-grant timeout that aborts stuck transfers.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   mem_port_arbiter_if.slave  io_bus
);

   typedef enum logic [1:0] {S_IDLE, S_GRANT_I, S_GRANT_D, S_RESP} state_t;

   localparam logic [15:0] LP_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   logic        r_owner;
   logic [15:0] r_count;
   logic        r_err;
   logic        r_m_read;
   logic        r_m_write;
   logic [31:0] r_m_address;
   logic [31:0] r_m_writedata;
   logic [3:0]  r_m_byteen;
   logic [31:0] r_i_readdata;
   logic [31:0] r_d_readdata;

   logic        w_i_req;
   logic        w_d_req;
   logic        w_grant_d;
   logic        w_in_resp;
   logic        w_timeout;

   assign w_i_req   = io_bus.i_read;
   assign w_d_req   = io_bus.d_read | io_bus.d_write;
   // On a tie the port that did not win last time gets the memory.
   assign w_grant_d = w_d_req & (~w_i_req | ~r_owner);
   assign w_in_resp = (r_state == S_RESP);
   assign w_timeout = (r_count == LP_LAST);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= S_IDLE;
         r_owner       <= 1'b0;
         r_count       <= 16'd0;
         r_err         <= 1'b0;
         r_m_read      <= 1'b0;
         r_m_write     <= 1'b0;
         r_m_address   <= 32'd0;
         r_m_writedata <= 32'd0;
         r_m_byteen    <= 4'd0;
         r_i_readdata  <= 32'd0;
         r_d_readdata  <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant_d) begin
                  r_state       <= S_GRANT_D;
                  r_owner       <= 1'b1;
                  r_m_read      <= io_bus.d_read & ~io_bus.d_write;
                  r_m_write     <= io_bus.d_write;
                  r_m_address   <= io_bus.d_address;
                  r_m_writedata <= io_bus.d_writedata;
                  r_m_byteen    <= io_bus.d_byteen;
               end else if (w_i_req) begin
                  r_state       <= S_GRANT_I;
                  r_owner       <= 1'b0;
                  r_m_read      <= 1'b1;
                  r_m_write     <= 1'b0;
                  r_m_address   <= io_bus.i_address;
                  r_m_writedata <= 32'd0;
                  r_m_byteen    <= 4'hF;
               end
            end
            S_GRANT_I, S_GRANT_D: begin
               // A completion in the last allowed cycle still counts as success.
               if (io_bus.m_ready) begin
                  if (r_state == S_GRANT_D) r_d_readdata <= io_bus.m_readdata;
                  else                      r_i_readdata <= io_bus.m_readdata;
                  r_m_read  <= 1'b0;
                  r_m_write <= 1'b0;
                  r_state   <= S_RESP;
               end else if (w_timeout) begin
                  if (r_state == S_GRANT_D) r_d_readdata <= 32'd0;
                  else                      r_i_readdata <= 32'd0;
                  r_err     <= 1'b1;
                  r_m_read  <= 1'b0;
                  r_m_write <= 1'b0;
                  r_state   <= S_RESP;
               end else begin
                  r_count <= r_count + 16'd1;
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
               r_count <= 16'd0;
               r_err   <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign io_bus.i_busywait  = w_i_req & ~(w_in_resp & ~r_owner);
   assign io_bus.d_busywait  = w_d_req & ~(w_in_resp & r_owner);
   assign io_bus.i_readdata  = r_i_readdata;
   assign io_bus.d_readdata  = r_d_readdata;
   assign io_bus.m_read      = r_m_read;
   assign io_bus.m_write     = r_m_write;
   assign io_bus.m_address   = r_m_address;
   assign io_bus.m_writedata = r_m_writedata;
   assign io_bus.m_byteen    = r_m_byteen;
   // The error flag is only ever set on entry to RESP, so it is a one-cycle pulse.
   assign io_bus.bus_error   = r_err;

endmodule
